seq_alu: RTL and testbench

Parametrised, multi-cycle successor of the 16-bit combinational ALU, sitting between the control unit and the accumulator/MBR datapath.
- Keeps the same 4-bit opcode map.
- Adds valid/ready handshakes and status flags.
- Replaces combinational multiply/divide with iterative shift-add multiply and restoring divide, returning a double-width product and a remainder.

---
 rtl/seq_alu.sv | 248 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes and status flags.
//   Single-cycle ops (add/sub/shift/rotate/logic/compare, divide-by-zero) finish on the
//   accepting edge. MUL (shift-add) and DIV (restoring) take WIDTH further cycles.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake (in_ready only in idle)
//   opcode, operand1/2    operation select and operands, latched on accept
//   out_valid/out_ready   result handshake; outputs held until out_ready
//   result, result_hi     primary result / product low / quotient; product high / remainder
//   flag_zero/carry/ovf/dz status flags registered with the result
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpMul  = 4'h2;
  localparam logic [3:0] OpDiv  = 4'h3;
  localparam logic [3:0] OpShl  = 4'h4;
  localparam logic [3:0] OpShr  = 4'h5;
  localparam logic [3:0] OpRol  = 4'h6;
  localparam logic [3:0] OpRor  = 4'h7;
  localparam logic [3:0] OpAnd  = 4'h8;
  localparam logic [3:0] OpOr   = 4'h9;
  localparam logic [3:0] OpXor  = 4'hA;
  localparam logic [3:0] OpNor  = 4'hB;
  localparam logic [3:0] OpNand = 4'hC;
  localparam logic [3:0] OpXnor = 4'hD;
  localparam logic [3:0] OpGt   = 4'hE;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Shared work register: {acc, multiplier} for MUL, {remainder, dividend} for DIV.
  logic [2*WIDTH-1:0]   work_q, work_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 dz_q, dz_d;

  // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_carry, alu_ovf, alu_dz;
  logic [WIDTH:0]   add_full, sub_full;

  always_comb begin
    add_full  = {1'b0, operand1} + {1'b0, operand2};
    sub_full  = {1'b0, operand1} - {1'b0, operand2};
    alu_res   = '0;
    alu_hi    = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_dz    = 1'b0;
    case (opcode)
      OpAdd: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                    (add_full[WIDTH-1] != operand1[WIDTH-1]);
      end
      OpSub: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
        alu_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                    (sub_full[WIDTH-1] != operand1[WIDTH-1]);
      end
      // Only divide-by-zero reaches the single-cycle path for DIV.
      OpDiv: begin
        alu_res = '1;
        alu_hi  = operand1;
        alu_dz  = 1'b1;
      end
      OpShl: begin
        alu_res   = {operand1[WIDTH-2:0], 1'b0};
        alu_carry = operand1[WIDTH-1];
      end
      OpShr: begin
        alu_res   = {1'b0, operand1[WIDTH-1:1]};
        alu_carry = operand1[0];
      end
      OpRol: begin
        alu_res   = {operand1[WIDTH-2:0], operand1[WIDTH-1]};
        alu_carry = operand1[WIDTH-1];
      end
      OpRor: begin
        alu_res   = {operand1[0], operand1[WIDTH-1:1]};
        alu_carry = operand1[0];
      end
      OpAnd:  alu_res = operand1 & operand2;
      OpOr:   alu_res = operand1 | operand2;
      OpXor:  alu_res = operand1 ^ operand2;
      OpNor:  alu_res = ~(operand1 | operand2);
      OpNand: alu_res = ~(operand1 & operand2);
      OpXnor: alu_res = ~(operand1 ^ operand2);
      OpGt:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
      default: alu_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
    endcase
  end

  // One shift-add multiply step: add multiplicand to the upper half when the
  // multiplier LSB is set, then shift the whole register right by one.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  // One restoring divide step: shift {rem, dividend} left, subtract divisor if it fits.
  logic [WIDTH:0]       div_trial;
  logic                 div_fits;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_step;

  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_sum, work_q[WIDTH-1:1]};
    div_trial = work_q[2*WIDTH-1:WIDTH-1];
    div_fits  = (div_trial >= {1'b0, opb_q});
    // The remainder after subtraction is below the divisor, so the low bits suffice.
    div_rem   = div_fits ? (div_trial[WIDTH-1:0] - opb_q) : div_trial[WIDTH-1:0];
    div_step  = {div_rem, work_q[WIDTH-2:0], div_fits};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    opb_d       = opb_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cnt_d = '0;
          if (opcode == OpMul) begin
            state_d = StMul;
            work_d  = {{WIDTH{1'b0}}, operand2};
            opb_d   = operand1;
          end else if (opcode == OpDiv && operand2 != '0) begin
            state_d = StDiv;
            work_d  = {{WIDTH{1'b0}}, operand1};
            opb_d   = operand2;
          end else begin
            state_d     = StDone;
            result_d    = alu_res;
            result_hi_d = alu_hi;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            dz_d        = alu_dz;
          end
        end
      end
      StMul: begin
        work_d = mul_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          cnt_d       = '0;
          result_d    = mul_step[WIDTH-1:0];
          result_hi_d = mul_step[2*WIDTH-1:WIDTH];
          zero_d      = (mul_step[WIDTH-1:0] == '0);
          carry_d     = (mul_step[2*WIDTH-1:WIDTH] != '0);
          ovf_d       = 1'b0;
          dz_d        = 1'b0;
        end
      end
      StDiv: begin
        work_d = div_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          cnt_d       = '0;
          result_d    = div_step[WIDTH-1:0];
          result_hi_d = div_step[2*WIDTH-1:WIDTH];
          zero_d      = (div_step[WIDTH-1:0] == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          dz_d        = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      work_q      <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_dz    = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        flag_zero;
  logic        flag_carry;
  logic        flag_ovf;
  logic        flag_dz;

  int checks;
  int failures;

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .flag_ovf  (flag_ovf),
    .flag_dz   (flag_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  flags;  // {zero, carry, ovf, dz}
    int          edges;  // clock edges after the accepting edge until out_valid
  } vec_t;

  localparam int NumVec = 24;
  vec_t vecs[NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, wait (bounded) for out_valid; busy_bad counts cycles with
  // in_ready high while the operation is still in progress.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int edges, output int busy_bad);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    operand1 = a;
    operand2 = b;
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    edges    = 0;
    busy_bad = 0;
    while (!out_valid && edges < 40) begin
      if (in_ready) busy_bad++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic check_outputs(input string name, input vec_t v, input int edges, input int busy_bad);
    chk({name, "_latency"}, edges, v.edges);
    chk({name, "_busy_in_ready"}, busy_bad, 32'd0);
    chk({name, "_result"}, {16'b0, result}, {16'b0, v.res});
    chk({name, "_result_hi"}, {16'b0, result_hi}, {16'b0, v.hi});
    chk({name, "_flags"}, {28'b0, flag_zero, flag_carry, flag_ovf, flag_dz}, {28'b0, v.flags});
  endtask

  initial begin
    int   edges;
    int   busy_bad;
    vec_t v;

    checks   = 0;
    failures = 0;
    //            op     a         b         res       hi        zcod     edges
    vecs[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100, 0};
    vecs[1]  = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0010, 0};
    vecs[2]  = '{4'h1, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 4'b0100, 0};
    vecs[3]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0010, 0};
    vecs[4]  = '{4'h4, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 4'b0100, 0};
    vecs[5]  = '{4'h5, 16'h8001, 16'h0000, 16'h4000, 16'h0000, 4'b0100, 0};
    vecs[6]  = '{4'h6, 16'h8001, 16'h0000, 16'h0003, 16'h0000, 4'b0100, 0};
    vecs[7]  = '{4'h7, 16'h8001, 16'h0000, 16'hC000, 16'h0000, 4'b0100, 0};
    vecs[8]  = '{4'h8, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0000, 0};
    vecs[9]  = '{4'h9, 16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 4'b0000, 0};
    vecs[10] = '{4'hA, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b1000, 0};
    vecs[11] = '{4'hB, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 4'b1000, 0};
    vecs[12] = '{4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 0};
    vecs[13] = '{4'hD, 16'h1234, 16'h1234, 16'hFFFF, 16'h0000, 4'b0000, 0};
    vecs[14] = '{4'hE, 16'h0005, 16'h0003, 16'h0001, 16'h0000, 4'b0000, 0};
    vecs[15] = '{4'hE, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 4'b1000, 0};
    vecs[16] = '{4'hF, 16'h1234, 16'h1234, 16'h0001, 16'h0000, 4'b0000, 0};
    vecs[17] = '{4'h3, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 4'b0001, 0};
    vecs[18] = '{4'h2, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0100, 16};
    vecs[19] = '{4'h2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0100, 16};
    vecs[20] = '{4'h2, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 4'b0000, 16};
    vecs[21] = '{4'h3, 16'd100,  16'd7,    16'd14,   16'd2,    4'b0000, 16};
    vecs[22] = '{4'h3, 16'd5,    16'd10,   16'd0,    16'd5,    4'b1000, 16};
    vecs[23] = '{4'h3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0000, 16};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'h0;
    operand1  = '0;
    operand2  = '0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", {result_hi, result}, 32'd0);
    chk("reset_flags", {28'b0, flag_zero, flag_carry, flag_ovf, flag_dz}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      v = vecs[i];
      run_op(v.op, v.a, v.b, edges, busy_bad);
      check_outputs($sformatf("vec%0d", i), v, edges, busy_bad);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: ROL held for 5 cycles with in_valid toggling on an ADD request.
    v = '{4'h6, 16'h8001, 16'h0000, 16'h0003, 16'h0000, 4'b0100, 0};
    run_op(v.op, v.a, v.b, edges, busy_bad);
    check_outputs("bp", v, edges, busy_bad);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      opcode   = 4'h0;
      operand1 = 16'h0010;
      operand2 = 16'h0020;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", k), {30'b0, out_valid, in_ready}, 32'd2);
      chk($sformatf("bp_hold%0d_data", k), {result_hi, result}, 32'h0000_0003);
      chk($sformatf("bp_hold%0d_flags", k),
          {28'b0, flag_zero, flag_carry, flag_ovf, flag_dz}, 32'b0100);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("bp");
    @(posedge clk);
    #1;
    chk("bp_no_stale_accept", {31'b0, out_valid}, 32'd0);

    // Reset pulse in the middle of a multiply discards it and clears outputs at once.
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 4'h2;
    operand1 = 16'h1234;
    operand2 = 16'h0100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("mid_mul_busy", {30'b0, out_valid, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_mul_reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_mul_reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_mul_reset_result", {result_hi, result}, 32'd0);
    chk("mid_mul_reset_flags", {28'b0, flag_zero, flag_carry, flag_ovf, flag_dz}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    v = '{4'h0, 16'd2, 16'd3, 16'd5, 16'h0000, 4'b0000, 0};
    run_op(v.op, v.a, v.b, edges, busy_bad);
    check_outputs("post_reset_add", v, edges, busy_bad);
    release_result("post_reset_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
